fn5_sched: RTL
==============

# fn5_sched

Shared-resource scheduler for the 5-bit function unit. Up to N requesters each present a 5-bit operand. The block grants one requester at a time in round-robin order and drives the operand into a single instance of the function unit. It holds the unit for a configurable number of execute cycles, then returns the 5-bit result tagged with the requester index over a valid/ready channel. It sits between the per-channel producers and the shared result consumer; only one transaction is in flight at any time.

## Interface
- N, 4: number of requesters, 2..8.
- EXEC_CYCLES, 2: cycles the function unit is held per transaction, ≥1.
- IDW, $clog2(N): width of the requester tag.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous and active-low (one clock, async active-low reset).
- req_valid  in  N  per-requester operand valid.
- req_data  in  5*N  operands; requester i uses bits [5i+4:5i].
- req_ready  out  N  one-hot (or zero) accept strobe.
- res_valid  out  1  result valid.
- res_data  out  5  function-unit result.
- res_id  out  IDW  requester index that owns res_data.
- res_ready  in  1  consumer accepts the result.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- Function unit: combinational, y = bit-reverse of x (y[k] = x[4-k]).
- FSM states:
  - IDLE → EXEC on any req_valid && req_ready handshake.
  - EXEC → RESP after EXEC_CYCLES cycles.
  - RESP → IDLE on res_valid && res_ready.
- IDLE:
  - Grant g is the first index with req_valid set, searching rr_ptr, rr_ptr+1, … mod N.
  - req_ready = one-hot(g) combinationally; all zero if no valid.
- Accept edge:
  - Latch operand and g into op_r and id_r, clear exec_cnt.
  - Set rr_ptr = (g+1) mod N.
- EXEC:
  - Function unit input = op_r. exec_cnt increments each cycle.
  - On the cycle exec_cnt == EXEC_CYCLES-1, register the unit output into res_data and enter RESP.
- RESP:
  - res_valid = 1. res_data and res_id stay stable until the handshake.
  - Back-pressure (res_ready = 0) holds RESP indefinitely.
- req_ready is 0 in EXEC and RESP. Requesters hold req_valid and req_data until accepted. A requester dropping req_valid before acceptance is legal and simply loses arbitration.
- Reset values: state IDLE, rr_ptr 0, req_ready 0, res_valid 0, res_data 0, res_id 0, busy 0, exec_cnt 0.
- Reset asserted mid-transaction: the in-flight operand and result are discarded, with no res_valid pulse afterwards.
- A requester index ≥ N cannot occur. rr_ptr wrap from N-1 goes to 0.

## Timing
- Accept at edge T. res_valid rises after edge T+EXEC_CYCLES, so it is first visible in cycle T+EXEC_CYCLES.
- RESP handshake at edge R: res_valid low and state IDLE after R. The next accept can occur at edge R+1, because one IDLE cycle is mandatory.
- Peak throughput is one result per EXEC_CYCLES+2 cycles.
- req_ready depends combinationally on req_valid and registered state only. There is no combinational path from res_ready to req_ready.
- If all N requesters are continuously valid, each is granted exactly once per N transactions.

## Structure
- Package fn5_pkg:
  - OPW = 5.
  - State enum {IDLE, EXEC, RESP}.
  - Function fn5_rev(x) for shared use by RTL and the bench model.
- Sub-module fn5_unit: combinational 5-bit in, 5-bit out, wrapping fn5_rev. It is instantiated once inside fn5_sched.
- Round-robin picker: inline rotate-and-priority-encode.

## Test plan
- Single request: req_valid = 4'b0100, req_data[14:10] = 5'b00110, res_ready = 1.
  - Expect req_ready = 4'b0100 for one cycle.
  - res_valid high 2 cycles after accept with res_data = 5'b01100, res_id = 2.
  - busy low afterwards.
- Round-robin fairness: all four valid with operands 5'b00001, 5'b00010, 5'b00100, 5'b01000 and res_ready = 1.
  - Expect res_id sequence 0,1,2,3,0.
  - res_data sequence 10000, 01000, 00100, 00010.
- Back-pressure: hold res_ready = 0 for 5 cycles in RESP.
  - res_valid, res_data and res_id stay stable.
  - req_ready stays 0000 despite pending requests.
  - The transaction completes on the first res_ready cycle.
- Wrap-around: rr_ptr at 3 with requests on 3 and 0.
  - Grant 3 first, then 0, and rr_ptr ends at 1.
- Palindrome and EXEC_CYCLES = 1: operand 5'b11011 returns 5'b11011 with res_valid one cycle after accept.
- Async reset in EXEC: assert rst_n = 0 between edges.
  - All outputs are 0 immediately.
  - No res_valid after release; the first grant after release starts from index 0.

Source files
------------

// File: rtl/fn5_pkg.sv
// Shared definitions for the 5-bit function-unit scheduler: operand width,
// FSM encodings and the bit-reverse function used by the unit and its model.
package fn5_pkg;

  localparam int OPW = 5;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t EXEC = 2'd1;
  localparam state_t RESP = 2'd2;

  function automatic logic [OPW-1:0] fn5_rev(input logic [OPW-1:0] x);
    logic [OPW-1:0] y;
    y = {OPW{1'b0}};
    for (int k = 0; k < OPW; k++) begin
      y[k] = x[OPW-1-k];
    end
    return y;
  endfunction

endpackage

// File: rtl/fn5_unit.sv
// Combinational 5-bit function unit: output is the bit-reversed operand.
module fn5_unit
  import fn5_pkg::*;
(
  input  logic [OPW-1:0] x_i,
  output logic [OPW-1:0] y_o
);

  assign y_o = fn5_rev(x_i);

endmodule

// File: rtl/fn5_sched.sv
// Round-robin scheduler sharing one fn5_unit among N requesters; one
// transaction in flight, result returned with its requester tag over valid/ready.
module fn5_sched
  import fn5_pkg::*;
#(
  parameter int N           = 4,
  parameter int EXEC_CYCLES = 2,
  parameter int IDW         = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_valid,
  input  logic [OPW*N-1:0] req_data,
  output logic [N-1:0]     req_ready,
  output logic             res_valid,
  output logic [OPW-1:0]   res_data,
  output logic [IDW-1:0]   res_id,
  input  logic             res_ready,
  output logic             busy
);

  localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  typedef logic [IDW:0]  ext_t;
  typedef logic [CW-1:0] cnt_t;

  localparam ext_t N_W      = ext_t'(N);
  localparam cnt_t CNT_LAST = cnt_t'(EXEC_CYCLES - 1);

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [OPW-1:0]   res_q, res_d;
  cnt_t             cnt_q, cnt_d;

  logic [IDW-1:0]   grant_s;
  logic             grant_vld_s;
  logic [OPW-1:0]   op_sel_s;
  logic [IDW-1:0]   rr_next_s;
  logic [OPW-1:0]   unit_y_s;
  ext_t             sum_s;
  ext_t             inc_s;

  // Rotating priority search: walk offsets high-to-low so the smallest offset from rr_q wins.
  always_comb begin
    grant_s     = {IDW{1'b0}};
    grant_vld_s = 1'b0;
    sum_s       = {(IDW+1){1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      sum_s = {1'b0, rr_q} + ext_t'(i);
      if (sum_s >= N_W) begin
        sum_s = sum_s - N_W;
      end else begin
        sum_s = sum_s;
      end
      if (req_valid[sum_s[IDW-1:0]]) begin
        grant_s     = sum_s[IDW-1:0];
        grant_vld_s = 1'b1;
      end else begin
        grant_s     = grant_s;
      end
    end
  end

  // Operand mux and pointer advance for the granted requester.
  always_comb begin
    op_sel_s = {OPW{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (grant_s == IDW'(i)) begin
        op_sel_s = req_data[i*OPW +: OPW];
      end else begin
        op_sel_s = op_sel_s;
      end
    end
    inc_s = {1'b0, grant_s} + ext_t'(1);
    if (inc_s == N_W) begin
      rr_next_s = {IDW{1'b0}};
    end else begin
      rr_next_s = inc_s[IDW-1:0];
    end
  end

  // Accept strobe only while idle; forced low while reset is asserted.
  always_comb begin
    req_ready = {N{1'b0}};
    if (rst_n && (state_q == IDLE) && grant_vld_s) begin
      req_ready[grant_s] = 1'b1;
    end else begin
      req_ready = {N{1'b0}};
    end
  end

  fn5_unit u_unit (
    .x_i (op_q),
    .y_o (unit_y_s)
  );

  // Next-state logic for the IDLE -> EXEC -> RESP transaction sequence.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    op_d    = op_q;
    id_d    = id_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_vld_s) begin
          state_d = EXEC;
          rr_d    = rr_next_s;
          op_d    = op_sel_s;
          id_d    = grant_s;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        cnt_d = cnt_q + cnt_t'(1);
        if (cnt_q == CNT_LAST) begin
          res_d   = unit_y_s;
          state_d = RESP;
        end else begin
          state_d = EXEC;
        end
      end
      RESP: begin
        if (res_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset discards any in-flight operand and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= {IDW{1'b0}};
      op_q    <= {OPW{1'b0}};
      id_q    <= {IDW{1'b0}};
      res_q   <= {OPW{1'b0}};
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      op_q    <= op_d;
      id_q    <= id_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  assign res_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign res_data  = res_q;
  assign res_id    = id_q;

endmodule
